// File: rtl/slope_gen.sv
// Triangle-wave sample generator: ramps lo->hi->lo by step, one sample per
// enabled clock, flagging the turning samples as peak/trough.
module slope_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             en,
  output logic [WIDTH-1:0] dataout,
  output logic             valid,
  output logic             dir,
  output logic             peak,
  output logic             trough,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state;
  logic [WIDTH-1:0] lo_q, hi_q, step_q;
  logic [WIDTH:0]   sum, diff;
  logic             hit_hi, hit_lo, cfg_bad;

  // One extra bit so a carry past the top or a borrow below zero clamps
  // to the limit instead of wrapping.
  assign sum    = {1'b0, dataout} + {1'b0, step_q};
  assign diff   = {1'b0, dataout} - {1'b0, step_q};
  assign hit_hi = sum >= {1'b0, hi_q};
  assign hit_lo = diff[WIDTH] || (diff[WIDTH-1:0] <= lo_q);

  // Judged on the incoming values so the flag lines up with the shadow regs.
  assign cfg_bad = (cfg_step == '0) || (cfg_lo >= cfg_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dataout <= '0;
      valid   <= 1'b0;
      dir     <= 1'b1;
      peak    <= 1'b0;
      trough  <= 1'b0;
      cfg_err <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '1;
      step_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (cfg_load) begin
      state   <= IDLE;
      valid   <= 1'b0;
      peak    <= 1'b0;
      trough  <= 1'b0;
      cfg_err <= cfg_bad;
      lo_q    <= cfg_lo;
      hi_q    <= cfg_hi;
      step_q  <= cfg_step;
    end else begin
      peak   <= 1'b0;
      trough <= 1'b0;
      valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && !cfg_err) begin
            dataout <= lo_q;
            valid   <= 1'b1;
            dir     <= 1'b1;
            state   <= UP;
          end
        end
        UP: begin
          if (en) begin
            valid <= 1'b1;
            if (hit_hi) begin
              dataout <= hi_q;
              peak    <= 1'b1;
              dir     <= 1'b0;
              state   <= DOWN;
            end else begin
              dataout <= sum[WIDTH-1:0];
            end
          end
        end
        DOWN: begin
          if (en) begin
            valid <= 1'b1;
            if (hit_lo) begin
              dataout <= lo_q;
              trough  <= 1'b1;
              dir     <= 1'b1;
              state   <= UP;
            end else begin
              dataout <= diff[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream slope detection treats these flags as ground truth.
  a_flags_excl: assert property (@(posedge clk) disable iff (rst) !(peak && trough));
  a_flags_vld:  assert property (@(posedge clk) disable iff (rst) (peak || trough) |-> valid);

endmodule

// File: tb/tb_slope_gen.sv
// Self-checking bench for slope_gen: directed test-plan sequences plus a
// randomized run against an integer-arithmetic reference model.
module tb_slope_gen;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, cfg_load, en;
  logic [W-1:0] cfg_lo, cfg_hi, cfg_step;
  logic [W-1:0] dataout;
  logic         valid, dir, peak, trough, cfg_err;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain integers, clamped ramp.
  int m_lo, m_hi, m_step, m_cur;
  bit m_run, m_up, m_v, m_pk, m_tr, m_err;

  slope_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_step(cfg_step), .en(en), .dataout(dataout), .valid(valid), .dir(dir),
    .peak(peak), .trough(trough), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cur = 0; m_v = 0; m_up = 1; m_pk = 0; m_tr = 0; m_err = 0; m_run = 0;
      m_lo = 0; m_hi = (1 << W) - 1; m_step = 1;
    end else if (cfg_load) begin
      m_lo = cfg_lo; m_hi = cfg_hi; m_step = cfg_step;
      m_err = (m_step == 0) || (m_lo >= m_hi);
      m_run = 0; m_v = 0; m_pk = 0; m_tr = 0;
    end else begin
      m_v = 0; m_pk = 0; m_tr = 0;
      if (en) begin
        if (!m_run) begin
          if (!m_err) begin
            m_cur = m_lo; m_v = 1; m_up = 1; m_run = 1;
          end
        end else if (m_up) begin
          m_v = 1;
          if (m_cur + m_step >= m_hi) begin m_cur = m_hi; m_pk = 1; m_up = 0; end
          else m_cur = m_cur + m_step;
        end else begin
          m_v = 1;
          if (m_cur - m_step <= m_lo) begin m_cur = m_lo; m_tr = 1; m_up = 1; end
          else m_cur = m_cur - m_step;
        end
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model, compare every output.
  task automatic cyc(input bit r, input bit ld, input bit e);
    rst = r; cfg_load = ld; en = e;
    @(posedge clk);
    #1;
    model_step();
    chk("dataout", 32'(dataout), 32'(m_cur));
    chk("valid",   32'(valid),   32'(m_v));
    chk("dir",     32'(dir),     32'(m_up));
    chk("peak",    32'(peak),    32'(m_pk));
    chk("trough",  32'(trough),  32'(m_tr));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic load(input int lo, input int hi, input int st);
    cfg_lo = W'(lo); cfg_hi = W'(hi); cfg_step = W'(st);
    cyc(0, 1, 0);
  endtask

  // Run enabled cycles and also compare against a hand-written sequence.
  task automatic expect_seq(input string tag, input int seq[$]);
    foreach (seq[i]) begin
      cyc(0, 0, 1);
      chk(tag, 32'(dataout), 32'(seq[i]));
      chk({tag, "_v"}, 32'(valid), 32'd1);
    end
  endtask

  initial begin
    rst = 1; cfg_load = 0; en = 0; cfg_lo = '0; cfg_hi = '0; cfg_step = '0;
    cyc(1, 0, 0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    cyc(0, 0, 0);

    // Basic ramp with turning flags
    load(10, 20, 4);
    expect_seq("basic", '{10, 14, 18, 20, 16, 12, 10, 14});

    // Overflow clamp
    load(0, 65535, 32768);
    expect_seq("ovf", '{0, 32768, 65535, 32767, 0});

    // Invalid configs block output; a good reload recovers
    load(5, 5, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("err_eq", 32'(cfg_err), 32'd1);
    load(0, 20, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("err_step0", 32'(cfg_err), 32'd1);
    load(0, 5, 1);
    chk("err_clr", 32'(cfg_err), 32'd0);
    expect_seq("recover", '{0, 1, 2});

    // Pause after 14, resume at 18
    load(10, 20, 4);
    expect_seq("pre_pause", '{10, 14});
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("pause_hold", 32'(dataout), 32'd14);
    expect_seq("resume", '{18, 20});

    // Mid-ramp reload at 16 descending
    expect_seq("to16", '{16});
    load(0, 8, 2);
    chk("reload_hold", 32'(dataout), 32'd16);
    expect_seq("reload", '{0, 2, 4, 6, 8, 6});

    // Reset mid-ramp restores default shadow config
    load(10, 20, 4);
    expect_seq("to18", '{10, 14, 18});
    cyc(1, 0, 1);
    chk("mid_rst", 32'(dataout), 32'd0);
    expect_seq("dflt", '{0, 1, 2, 3});

    // Narrow range
    load(3, 5, 7);
    expect_seq("narrow", '{3, 5, 3, 5});
    chk("narrow_pk", 32'(peak), 32'd1);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 3) begin
        if ($urandom_range(0, 1) == 1) begin
          cfg_lo = W'($urandom_range(0, 40));
          cfg_hi = W'($urandom_range(0, 60));
          cfg_step = W'($urandom_range(0, 9));
        end else begin
          cfg_lo = W'($urandom); cfg_hi = W'($urandom); cfg_step = W'($urandom);
        end
        cyc(0, 1, $urandom_range(0, 1) == 1);
      end else if (k == 3) begin
        cyc(1, 0, 1);
      end else begin
        cyc(0, 0, $urandom_range(0, 9) < 7);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
